stream_demux: RTL and testbench
===============================

# stream_demux

Parametrised, registered 1:N stream demultiplexer: routes a valid/ready data stream to one of `NUM_CH` output channels. Packets are delimited by `in_last`. The channel is latched on the first beat of each packet and held until the last beat. Each output has a one-entry register stage. The block sits between a single producer and `NUM_CH` independent consumers.

## Interface
Parameters:
- `DATA_W`, 8 — payload width per beat.
- `NUM_CH`, 4 — number of output channels, 2..16.
- `SEL_W`, `$clog2(NUM_CH)` — select width; derived, do not override.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_data`  in  DATA_W  — input beat payload.
- `in_sel`  in  SEL_W  — destination channel; sampled only on the first beat of a packet.
- `in_last`  in  1  — marks the final beat of a packet.
- `in_valid`  in  1  — producer has a beat.
- `in_ready`  out  1  — block accepts the beat this cycle.
- `out_data`  out  NUM_CH*DATA_W  — channel k occupies bits [k*DATA_W +: DATA_W].
- `out_last`  out  NUM_CH  — per-channel last flag.
- `out_valid`  out  NUM_CH  — per-channel valid.
- `out_ready`  in  NUM_CH  — per-channel consumer ready.
- `err`  out  1  — one-cycle pulse when a packet is dropped because of an out-of-range select.
- `stat_cnt`  out  NUM_CH*16  — per-channel accepted-beat counters (see Configuration).

## Operation
- FSM states:
  - `IDLE` — awaiting the first beat of a packet.
  - `ROUTE` — mid-packet, channel locked in `cur_ch`.
  - `DROP` — mid-packet, beats discarded.
- Effective channel: `eff_ch = (state==IDLE) ? in_sel : cur_ch`.
- Beat accepted (`acc`) when `in_valid && in_ready`.
- `in_ready` rules:
  - `IDLE` with `in_sel >= NUM_CH`: `in_ready` = 1; the beat is discarded.
  - `DROP`: `in_ready` = 1.
  - Otherwise: `in_ready = !out_valid[eff_ch] || out_ready[eff_ch]`.
- FSM transitions:
  - `IDLE`, acc, valid sel, !last → `ROUTE`, `cur_ch <= in_sel`.
  - `IDLE`, acc, valid sel, last → stay `IDLE` (single-beat packet).
  - `IDLE`, acc, invalid sel → `err` pulse next cycle; go to `DROP` if !last, else stay `IDLE`.
  - `ROUTE`/`DROP`, acc with `in_last` → `IDLE`.
- Output register k:
  - On acc to k: load data/last and set `out_valid[k]`.
  - Else if `out_ready[k]`: clear `out_valid[k]`.
  - Load and drain in the same cycle keeps valid = 1 with the new data.
- Non-selected channels hold their state; other channels drain independently of `in_*`.
- `in_sel` changes mid-packet are ignored.

## Timing
- Reset values:
  - `state` = `IDLE`, `cur_ch` = 0.
  - All `out_valid` = 0; `out_data` and `out_last` = 0.
  - `err` = 0; `stat_cnt` = 0.
- Latency: a beat accepted at edge n is visible on `out_*` after edge n (one register).
- Throughput: one beat per cycle per packet while the destination consumer holds ready.
- `in_ready` is combinational from `out_ready`, `out_valid`, `state` and `in_sel`. There is no combinational path from `in_valid` to `in_ready`.
- `err` is registered: high for exactly one cycle, the cycle after the dropping first beat.
- Reset mid-packet: FSM returns to `IDLE` and all buffered beats are discarded. The producer must restart on a packet boundary.
- `rst` has priority over all other events in the same cycle.

## Configuration
- `STREAM_DEMUX_STATS_EN` defined:
  - One 16-bit counter per channel, incremented on each accepted beat routed to that channel.
  - Counters saturate at 0xFFFF and clear only on `rst`.
  - Dropped beats are not counted.
- Undefined: `stat_cnt` is tied to 0 and no counter logic is synthesised. The port list is unchanged.

## Structure
- Shared package `stream_demux_pkg`:
  - FSM state enum (`IDLE`, `ROUTE`, `DROP`).
  - `STAT_W` = 16.
  - `MAX_CH` = 16.
- Sub-module `stream_demux_slot`: one per-channel output register with load/drain logic and an optional stat counter; instantiated `NUM_CH` times in a generate loop.
- Top level holds the FSM, `eff_ch` decode, `in_ready` mux and `err`.

## Test plan
- Reset then idle: after `rst` = 1 for 2 cycles, all `out_valid` = 0, `in_ready` = 1, `stat_cnt` = 0.
- Single-beat routing: DATA_W=8, NUM_CH=4; send `in_sel`=2, data 0xA5, last=1 with `out_ready` all 1 → `out_valid[2]`=1 with data 0xA5, last=1 one cycle later; other channels stay 0.
- Packet lock: 3-beat packet 0x11/0x22/0x33 with `in_sel`=1 on beat 0, `in_sel` changed to 3 on beats 1–2 → all three beats appear on channel 1 only.
- Backpressure: `out_ready[0]`=0 while channel 0 holds a beat → `in_ready`=0 for channel-0 traffic. Channel-3 traffic is still accepted at the same time.
- Drop: NUM_CH=3, `in_sel`=3, 2-beat packet → `in_ready`=1 throughout, `err` high for exactly 1 cycle, no `out_valid` set; the next packet with `in_sel`=0 routes normally.
- Stats and reset mid-packet (STATS_EN defined): 5 beats to channel 0 → `stat_cnt[15:0]`=5; assert `rst` mid-packet → FSM returns to `IDLE`, counters = 0, next first beat re-samples `in_sel`.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
// Optional per-channel beat counters: STREAM_DEMUX_STATS_EN.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_e;

    localparam int STAT_W = 16;
    localparam int MAX_CH = 16;

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One output channel: single-entry register stage plus optional
// beat counter (present only with STREAM_DEMUX_STATS_EN).
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    output logic [STAT_W-1:0] stat_cnt
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;

    // Load wins over drain so a beat can replace the one leaving.
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = ld_data;
            last_d  = ld_last;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Register stage; reset discards any buffered beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

`ifdef STREAM_DEMUX_STATS_EN
    logic [STAT_W-1:0] cnt_q, cnt_d;

    // Count every beat routed here; saturate rather than wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Counter clears only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stat_cnt = cnt_q;
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: rtl/stream_demux.sv
// Registered 1:N packet demultiplexer with channel lock per packet.
// Build option: STREAM_DEMUX_STATS_EN enables per-channel counters.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_last,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic                     err,
    output logic [NUM_CH*STAT_W-1:0] stat_cnt
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] eff_ch;
    logic             sel_bad;
    logic             acc;
    logic             route;

    // Channel select, ready mux and accept decode.
    always_comb begin
        eff_ch   = (state_q == IDLE) ? in_sel : cur_ch_q;
        sel_bad  = (state_q == IDLE) && (int'(in_sel) >= NUM_CH);
        in_ready = 1'b1;
        if (!sel_bad && state_q != DROP && int'(eff_ch) < NUM_CH) begin
            in_ready = !out_valid[eff_ch] || out_ready[eff_ch];
        end
        acc   = in_valid && in_ready;
        route = acc && !sel_bad && (state_q != DROP);
    end

    // Packet FSM: lock channel on first beat, release on last.
    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (sel_bad) begin
                        err_d = 1'b1;
                        if (!in_last) state_d = DROP;
                    end else if (!in_last) begin
                        state_d  = ROUTE;
                        cur_ch_d = in_sel;
                    end
                end
            end
            ROUTE, DROP: begin
                if (acc && in_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_ch_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        logic load;
        assign load = route && (eff_ch == SEL_W'(k));

        stream_demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load),
            .ld_data   (in_data),
            .ld_last   (in_last),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W]),
            .out_last  (out_last[k]),
            .out_valid (out_valid[k]),
            .stat_cnt  (stat_cnt[k*STAT_W +: STAT_W])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: 4-channel scoreboard instance
// plus a 3-channel instance for out-of-range select drops.
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst;

    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_last;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        err;
    logic [63:0] stat_cnt;

    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic        b_in_last;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [23:0] b_out_data;
    logic [2:0]  b_out_last;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic        b_err;
    logic [47:0] b_stat_cnt;

    always #5 clk = ~clk;

    stream_demux #(.DATA_W(8), .NUM_CH(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .err(err), .stat_cnt(stat_cnt)
    );

    stream_demux #(.DATA_W(8), .NUM_CH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_last(b_in_last),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .err(b_err), .stat_cnt(b_stat_cnt)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0]  sbq[4][$];
    int          exp_cnt[4];
    logic        mdl_busy;
    logic [1:0]  mdl_ch;
    bit          last_acc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] stat_exp();
        logic [63:0] v = '0;
`ifdef STREAM_DEMUX_STATS_EN
        for (int k = 0; k < 4; k++) v[k*16 +: 16] = 16'(exp_cnt[k]);
`endif
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            sbq[k].delete();
            exp_cnt[k] = 0;
        end
        mdl_busy = 1'b0;
        mdl_ch   = 2'd0;
    endtask

    // Called at the falling edge: settle drains and acceptances
    // that happen on the next rising edge.
    task automatic mon();
        logic [1:0] ch;
        logic [8:0] e;
        for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                if (sbq[k].size() == 0) begin
                    chk($sformatf("spurious_ch%0d", k), 64'(out_valid[k]), 64'd0);
                end else begin
                    e = sbq[k].pop_front();
                    chk($sformatf("ch%0d_beat", k),
                        64'({out_last[k], out_data[k*8 +: 8]}), 64'(e));
                end
            end
        end
        last_acc = in_valid && in_ready && !rst;
        if (last_acc) begin
            ch = mdl_busy ? mdl_ch : in_sel;
            sbq[ch].push_back({in_last, in_data});
            if (exp_cnt[ch] < 65535) exp_cnt[ch]++;
            mdl_busy = !in_last;
            mdl_ch   = ch;
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mon();
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_beat(input logic [1:0] sel, input logic [7:0] d,
                             input logic l, output int waits);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        in_last  = l;
        waits    = 0;
        while (!got && waits < 20) begin
            @(negedge clk);
            mon();
            got = last_acc;
            @(posedge clk);
            #2;
            if (!got) waits++;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 64'(got), 64'd1);
    endtask

    initial begin
        int w;
        int sb_left;
        rst = 1'b1;
        in_data = '0; in_sel = '0; in_last = 1'b0; in_valid = 1'b0;
        out_ready = 4'hF;
        b_in_data = '0; b_in_sel = '0; b_in_last = 1'b0; b_in_valid = 1'b0;
        b_out_ready = 3'h7;
        model_clear();
        last_acc = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stat", stat_cnt, 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        send_beat(2'd2, 8'hA5, 1'b1, w);
        chk("single_valid", 64'(out_valid), 64'h4);
        chk("single_data", 64'(out_data[23:16]), 64'hA5);
        chk("single_last", 64'(out_last[2]), 64'd1);
        cyc(2);
        chk("single_drained", 64'(out_valid), 64'd0);

        send_beat(2'd1, 8'h11, 1'b0, w);
        chk("lock_b0", 64'(out_valid), 64'h2);
        send_beat(2'd3, 8'h22, 1'b0, w);
        chk("lock_b1", 64'(out_valid), 64'h2);
        send_beat(2'd3, 8'h33, 1'b1, w);
        chk("lock_b2", 64'(out_valid), 64'h2);
        chk("lock_b2_data", 64'(out_data[15:8]), 64'h33);
        cyc(2);

        out_ready = 4'b1110;
        send_beat(2'd0, 8'h44, 1'b1, w);
        chk("bp_hold", 64'(out_valid), 64'h1);
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h55; in_last = 1'b1;
        #1;
        chk("bp_ready_ch0", 64'(in_ready), 64'd0);
        in_sel = 2'd3;
        #1;
        chk("bp_ready_ch3", 64'(in_ready), 64'd1);
        send_beat(2'd3, 8'h66, 1'b1, w);
        chk("bp_ch3_wait", 64'(w), 64'd0);
        chk("bp_both", 64'(out_valid), 64'h9);
        chk("bp_ch0_data", 64'(out_data[7:0]), 64'h44);
        out_ready = 4'hF;
        cyc(2);

        for (int i = 0; i < 4; i++) begin
            send_beat(2'd2, 8'hB0 + 8'(i), 1'(i == 3), w);
            chk($sformatf("thru_wait%0d", i), 64'(w), 64'd0);
        end
        cyc(2);

        b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'h77; b_in_last = 1'b0;
        #1;
        chk("drop_ready0", 64'(b_in_ready), 64'd1);
        cyc();
        chk("drop_err_hi", 64'(b_err), 64'd1);
        b_in_sel = 2'd0; b_in_data = 8'h78; b_in_last = 1'b1;
        #1;
        chk("drop_ready1", 64'(b_in_ready), 64'd1);
        cyc();
        chk("drop_err_lo", 64'(b_err), 64'd0);
        chk("drop_no_valid", 64'(b_out_valid), 64'd0);
        b_in_sel = 2'd0; b_in_data = 8'h88; b_in_last = 1'b1;
        cyc();
        b_in_valid = 1'b0;
        chk("drop_next_valid", 64'(b_out_valid), 64'h1);
        chk("drop_next_data", 64'(b_out_data[7:0]), 64'h88);
        chk("drop_next_err", 64'(b_err), 64'd0);
        cyc();

        sb_left = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
        chk("sb_drain_a", 64'(sb_left), 64'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) send_beat(2'd0, 8'(i + 1), 1'(i == 4), w);
        cyc(2);
        chk("stat_five", stat_cnt, stat_exp());

        send_beat(2'd2, 8'hC1, 1'b0, w);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_clear();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_stat", stat_cnt, 64'd0);
        send_beat(2'd1, 8'hD1, 1'b1, w);
        chk("midrst_resample", 64'(out_valid), 64'h2);
        cyc(3);
        sb_left = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
        chk("sb_drain_b", 64'(sb_left), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
